// File: rtl/mccpu_if.sv
// Shared instruction/data memory port for mccpu.
//   master (core):   mem_req, mem_we, mem_addr, mem_be, mem_wdata out; mem_ack, mem_rdata in
//   slave  (memory): the same signals with directions reversed
interface mccpu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mccpu.sv
// Multi-cycle MIPS-I subset core with a single shared instruction/data port.
//   clk, rst    clock and synchronous active-high reset
//   bus         memory port (mccpu_if.master): request held until ack
//   reg_sel     debug register index; reg_data is GPR[reg_sel], combinational
//   retire      one-cycle pulse per completed instruction
//   halt        high while trapped; trap_cause 1 illegal, 2 misaligned, 3 bus timeout
module mccpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    mccpu_if.master     bus,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data,
    output logic        retire,
    output logic        halt,
    output logic [1:0]  trap_cause
);
    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StTrap   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, wait_q;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] gpr_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, dest;
    logic [31:0] sext, imm_ext, alu_res, ld_val;
    logic        legal, wr_rd, zext_imm, is_load, is_store, is_branch, is_j, is_jal, is_jr;
    logic        taken, misal, timeout, req, retire_c;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign sext    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_ext = zext_imm ? {16'h0, ir_q[15:0]} : sext;
    assign dest    = wr_rd ? rd : rt;
    assign taken   = (opcode == 6'h04) ? (a_q == b_q) : (a_q != b_q);
    // Word accesses (lw/sw) have opcode[1:0] == 2'b11; byte accesses never trap.
    assign misal   = (is_load || is_store) && (opcode[1:0] == 2'b11) && (alu_q[1:0] != 2'b00);
    assign timeout = (MAX_WAIT != 0) && (wait_q == 32'(MAX_WAIT - 1));

    always_comb begin
        legal = 1'b0; wr_rd = 1'b0; zext_imm = 1'b0; is_load = 1'b0; is_store = 1'b0;
        is_branch = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03: begin
                        legal = 1'b1;
                        wr_rd = 1'b1;
                    end
                    6'h08:   begin legal = 1'b1; is_jr = 1'b1; end
                    default: ;
                endcase
            end
            6'h09, 6'h0a, 6'h0f: legal = 1'b1;
            6'h0c, 6'h0d, 6'h0e: begin legal = 1'b1; zext_imm = 1'b1; end
            6'h23, 6'h20, 6'h24: begin legal = 1'b1; is_load = 1'b1; end
            6'h2b, 6'h28:        begin legal = 1'b1; is_store = 1'b1; end
            6'h04, 6'h05:        begin legal = 1'b1; is_branch = 1'b1; end
            6'h02:               begin legal = 1'b1; is_j = 1'b1; end
            6'h03:               begin legal = 1'b1; is_j = 1'b1; is_jal = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = a_q + imm_ext;
        if (opcode == 6'h00) begin
            case (funct)
                6'h21:   alu_res = a_q + b_q;
                6'h23:   alu_res = a_q - b_q;
                6'h24:   alu_res = a_q & b_q;
                6'h25:   alu_res = a_q | b_q;
                6'h27:   alu_res = ~(a_q | b_q);
                6'h2a:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
                6'h2b:   alu_res = {31'b0, a_q < b_q};
                6'h00:   alu_res = b_q << shamt;
                6'h02:   alu_res = b_q >> shamt;
                6'h03:   alu_res = 32'($signed(b_q) >>> shamt);
                default: alu_res = '0;
            endcase
        end else begin
            case (opcode)
                6'h0a:   alu_res = {31'b0, $signed(a_q) < $signed(imm_ext)};
                6'h0c:   alu_res = a_q & imm_ext;
                6'h0d:   alu_res = a_q | imm_ext;
                6'h0e:   alu_res = a_q ^ imm_ext;
                6'h0f:   alu_res = {ir_q[15:0], 16'h0};
                default: alu_res = a_q + imm_ext;
            endcase
        end
    end

    always_comb begin
        ld_val = bus.mem_rdata;
        if (opcode != 6'h23) begin
            case (alu_q[1:0])
                2'd0:    ld_val = {24'h0, bus.mem_rdata[7:0]};
                2'd1:    ld_val = {24'h0, bus.mem_rdata[15:8]};
                2'd2:    ld_val = {24'h0, bus.mem_rdata[23:16]};
                default: ld_val = {24'h0, bus.mem_rdata[31:24]};
            endcase
            if (opcode == 6'h20) ld_val[31:8] = {24{ld_val[7]}};
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        req           = 1'b0;
        retire_c      = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc_q;
        bus.mem_be    = 4'hF;
        bus.mem_wdata = (opcode == 6'h28) ? {4{b_q[7:0]}} : b_q;
        case (state_q)
            StFetch: begin
                req = 1'b1;
                if (bus.mem_ack) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 2'd3;
                end
            end
            StDecode: begin
                state_d = legal ? StExec : StTrap;
                if (!legal) cause_d = 2'd1;
            end
            StExec: begin
                if (is_branch || is_j || is_jr) begin
                    state_d  = StFetch;
                    retire_c = 1'b1;
                end else begin
                    state_d = (is_load || is_store) ? StMem : StWb;
                end
            end
            StMem: begin
                bus.mem_addr = {alu_q[31:2], 2'b00};
                bus.mem_we   = is_store;
                if (opcode[1:0] != 2'b11) bus.mem_be = 4'b0001 << alu_q[1:0];
                if (misal) begin
                    state_d = StTrap;
                    cause_d = 2'd2;
                end else begin
                    req = 1'b1;
                    if (bus.mem_ack) begin
                        state_d  = is_store ? StFetch : StWb;
                        retire_c = is_store;
                    end else if (timeout) begin
                        state_d = StTrap;
                        cause_d = 2'd3;
                    end
                end
            end
            StWb: begin
                state_d  = StFetch;
                retire_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req = req && !rst;
    assign retire      = retire_c && !rst;
    assign halt        = (state_q == StTrap) && !rst;
    assign trap_cause  = cause_q;
    assign reg_data    = (reg_sel == 5'd0) ? 32'h0 : gpr_q[reg_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            wait_q  <= '0;
            cause_q <= 2'd0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            // Any state change is an entry into a new phase, so the counter restarts.
            if (state_d != state_q)          wait_q <= '0;
            else if (req && !bus.mem_ack)    wait_q <= wait_q + 32'd1;
            case (state_q)
                StFetch: begin
                    if (bus.mem_ack) begin
                        ir_q <= bus.mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                StDecode: begin
                    a_q <= gpr_q[rs];
                    b_q <= gpr_q[rt];
                end
                StExec: begin
                    alu_q <= alu_res;
                    // pc_q already points past the branch/jump instruction.
                    if (is_branch && taken) pc_q <= pc_q + {sext[29:0], 2'b00};
                    if (is_j)               pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    if (is_jr)              pc_q <= a_q;
                    if (is_jal)             gpr_q[31] <= pc_q;
                end
                StMem: begin
                    if (!misal && bus.mem_ack && is_load) alu_q <= ld_val;
                end
                StWb: begin
                    if (dest != 5'd0) gpr_q[dest] <= alu_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mccpu.sv
module tb_mccpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] reg_data, reg_data2;
    logic        retire, halt, retire2, halt2;
    logic [1:0]  cause, cause2;

    logic [31:0] mem [128];
    int          wcnt = 0;
    int          lat = 0;
    logic        stray_ack = 1'b0;
    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [6:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    int          ncmp = 0;
    int          nfail = 0;
    int          nret;

    always #5 clk = ~clk;

    mccpu_if bus ();
    mccpu_if bus2 ();

    mccpu #(.RESET_PC(32'h0000_0000), .MAX_WAIT(255)) dut (
        .clk(clk), .rst(rst), .bus(bus), .reg_sel(reg_sel), .reg_data(reg_data),
        .retire(retire), .halt(halt), .trap_cause(cause)
    );

    // Second core on a memory that never acknowledges, for the bus timeout.
    mccpu #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .reg_sel(5'd0), .reg_data(reg_data2),
        .retire(retire2), .halt(halt2), .trap_cause(cause2)
    );

    assign bus.mem_ack    = (bus.mem_req && (wcnt >= lat)) || stray_ack;
    assign bus.mem_rdata  = mem[bus.mem_addr[8:2]];
    assign bus2.mem_ack   = 1'b0;
    assign bus2.mem_rdata = 32'h0;

    always @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr[8:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b1;
        #1;
    endtask

    task automatic load(input logic [31:0] byte_addr, input logic [31:0] data);
        @(negedge clk);
        clr     = 1'b0;
        ld_en   = 1'b1;
        ld_addr = byte_addr[8:2];
        ld_data = data;
    endtask

    // Leaves the bench sampling cycle 1 (first FETCH cycle) after reset.
    task automatic release_reset();
        @(negedge clk);
        clr   = 1'b0;
        ld_en = 1'b0;
        rst   = 1'b0;
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        reg_sel = r;
        #1;
        check(tag, reg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        // addiu / addu chain, zero-wait
        lat = 0;
        begin_reset();
        load(32'h00, 32'h2401_0005);
        load(32'h04, 32'h2422_FFF9);
        load(32'h08, 32'h0022_1821);
        load(32'h0C, 32'h1000_FFFF);
        release_reset();
        check("rst_req", bus.mem_req, 1'b1);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_halt", halt, 1'b0);
        check("rst_cause", cause, 2'd0);
        nret = 0;
        for (int i = 0; i < 12; i++) begin
            if (retire) nret++;
            cyc(1);
        end
        check("add_retires", nret, 3);
        chk_reg("r1", 5'd1, 32'h0000_0005);
        chk_reg("r2", 5'd2, 32'hFFFF_FFFE);
        chk_reg("r3", 5'd3, 32'h0000_0003);

        // lw with a three-cycle wait on every request
        lat = 3;
        begin_reset();
        load(32'h00, 32'h8C04_0008);
        load(32'h04, 32'h1000_FFFF);
        load(32'h08, 32'hDEAD_BEEF);
        release_reset();
        chk_reg("gpr_cleared", 5'd3, 32'h0);
        nret = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c <= 4) check("fetch_addr_stable", bus.mem_addr, 32'h0);
            if (c <= 4) check("fetch_req_held", bus.mem_req, 1'b1);
            if (c >= 7 && c <= 10) check("lw_addr_stable", bus.mem_addr, 32'h8);
            if (retire) nret++;
            cyc(1);
        end
        check("lw_retires", nret, 1);
        chk_reg("r4", 5'd4, 32'hDEAD_BEEF);

        // sb / lb / lbu on byte lane 3
        lat = 0;
        begin_reset();
        load(32'h00, 32'h2405_00A5);
        load(32'h04, 32'hA005_0003);
        load(32'h08, 32'h8006_0003);
        load(32'h0C, 32'h9007_0003);
        load(32'h10, 32'h1000_FFFF);
        release_reset();
        cyc(7);
        check("sb_we", bus.mem_we, 1'b1);
        check("sb_be", bus.mem_be, 4'b1000);
        check("sb_lane", bus.mem_wdata[31:24], 8'hA5);
        check("sb_addr", bus.mem_addr, 32'h0);
        cyc(11);
        chk_reg("lb_r6", 5'd6, 32'hFFFF_FFA5);
        chk_reg("lbu_r7", 5'd7, 32'h0000_00A5);

        // Shift / compare / lui / ori
        begin_reset();
        load(32'h00, 32'h3C09_8000);
        load(32'h04, 32'h0009_5103);
        load(32'h08, 32'h0009_582B);
        load(32'h0C, 32'h0120_602A);
        load(32'h10, 32'h352D_8001);
        load(32'h14, 32'h1000_FFFF);
        release_reset();
        cyc(21);
        chk_reg("lui_r9", 5'd9, 32'h8000_0000);
        chk_reg("sra_r10", 5'd10, 32'hF800_0000);
        chk_reg("sltu_r11", 5'd11, 32'h1);
        chk_reg("slt_r12", 5'd12, 32'h1);
        chk_reg("ori_r13", 5'd13, 32'h8000_8001);

        // j to a beq self-loop at 0x10
        begin_reset();
        load(32'h00, 32'h0800_0004);
        load(32'h10, 32'h1000_FFFF);
        release_reset();
        cyc(3);
        check("j_target", bus.mem_addr, 32'h10);
        cyc(1);
        check("decode_noreq", bus.mem_req, 1'b0);
        cyc(1);
        check("beq_retire", retire, 1'b1);
        cyc(1);
        check("beq_iter1", bus.mem_addr, 32'h10);
        cyc(3);
        check("beq_iter2", bus.mem_addr, 32'h10);
        check("beq_iter2_req", bus.mem_req, 1'b1);

        // jal 0x40 from 0x20
        begin_reset();
        load(32'h00, 32'h0800_0008);
        load(32'h20, 32'h0C00_0040);
        load(32'h100, 32'h1000_FFFF);
        release_reset();
        cyc(5);
        check("jal_retire", retire, 1'b1);
        cyc(1);
        check("jal_target", bus.mem_addr, 32'h100);
        chk_reg("jal_r31", 5'd31, 32'h24);

        // Illegal opcode
        begin_reset();
        load(32'h00, 32'hFC00_0000);
        release_reset();
        cyc(2);
        check("ill_halt", halt, 1'b1);
        check("ill_cause", cause, 2'd1);
        check("ill_noreq", bus.mem_req, 1'b0);
        cyc(3);
        check("ill_frozen_req", bus.mem_req, 1'b0);
        check("ill_no_retire", retire, 1'b0);
        begin_reset();
        check("rst_clears_halt", halt, 1'b0);

        // Misaligned lw
        load(32'h00, 32'h8C01_0002);
        release_reset();
        cyc(3);
        check("mis_noreq", bus.mem_req, 1'b0);
        cyc(1);
        check("mis_halt", halt, 1'b1);
        check("mis_cause", cause, 2'd2);

        // Bus timeout on the never-acked core
        begin_reset();
        release_reset();
        for (int c = 1; c <= 4; c++) begin
            check("to_req", bus2.mem_req, 1'b1);
            cyc(1);
        end
        check("to_dropreq", bus2.mem_req, 1'b0);
        check("to_halt", halt2, 1'b1);
        check("to_cause", cause2, 2'd3);

        // Reset during the MEM wait, with a stray ack in the reset cycle
        lat = 3;
        begin_reset();
        load(32'h00, 32'h8C04_0008);
        load(32'h08, 32'h1234_5678);
        release_reset();
        cyc(9);
        check("pre_rst_memreq", bus.mem_req, 1'b1);
        check("pre_rst_addr", bus.mem_addr, 32'h8);
        rst = 1'b1;
        stray_ack = 1'b1;
        #1;
        check("midrst_req", bus.mem_req, 1'b0);
        check("midrst_halt", halt, 1'b0);
        check("midrst_retire", retire, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        stray_ack = 1'b0;
        #1;
        check("postrst_req", bus.mem_req, 1'b1);
        check("postrst_addr", bus.mem_addr, 32'h0);
        chk_reg("postrst_r4", 5'd4, 32'h0);

        // Writes to $0 are discarded
        lat = 0;
        begin_reset();
        load(32'h00, 32'h2400_0007);
        load(32'h04, 32'h0000_4021);
        load(32'h08, 32'h1000_FFFF);
        release_reset();
        cyc(8);
        chk_reg("r0_read", 5'd0, 32'h0);
        chk_reg("r8_from_r0", 5'd8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
